reg_scoreboard: RTL and testbench

Per-register write-pending scoreboard for the pipelined LC-3b datapath. It consumes the decode-stage dependency flags (destination produced, SR1/SR2/store-source needed), tracks issued register writes that have not yet reached writeback, and stalls decode on any read-after-write hazard against an in-flight writer. It sits between the decode-stage dependency calculator and the ID/EX pipeline register. Writeback retires entries.

---
 rtl/reg_scoreboard.sv | 88 ++++++++
 tb/tb_reg_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register write-pending scoreboard with RAW stall for LC-3b decode
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic       dec_advance,
    input  logic       produces_dr,
    input  logic       need_sr1,
    input  logic       need_sr2,
    input  logic       need_Hsr,
    input  logic [2:0] dec_dr,
    input  logic [2:0] dec_sr1,
    input  logic [2:0] dec_sr2,
    input  logic       wb_valid,
    input  logic [2:0] wb_dr,
    input  logic       flush,
    output logic       stall,
    output logic       issue,
    output logic [7:0] pending_mask,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] pend      [8];
    logic [CNT_W-1:0] pend_next [8];
    logic [7:0]       mask_next;
    logic [7:0]       inc_vec;
    logic [7:0]       dec_vec;
    logic             hazard;
    logic             underflow;

    // Hazard against registered counts only; a same-cycle retire is not bypassed.
    always_comb begin
        hazard = dec_valid & (
                   (need_sr1    & (pend[dec_sr1] != '0)) |
                   (need_sr2    & (pend[dec_sr2] != '0)) |
                   (need_Hsr    & (pend[dec_dr]  != '0)) |
                   (produces_dr & (pend[dec_dr]  == CNT_MAX)));
        stall  = hazard;
        issue  = dec_valid & dec_advance & ~hazard & ~flush;
    end

    // Next counter values: flush wins, same-register issue+retire nets to zero.
    always_comb begin
        underflow = 1'b0;
        inc_vec   = '0;
        dec_vec   = '0;
        mask_next = '0;
        for (int i = 0; i < 8; i++) begin
            inc_vec[i]   = issue & produces_dr & (dec_dr == 3'(i));
            dec_vec[i]   = wb_valid & (wb_dr == 3'(i));
            pend_next[i] = pend[i];
            if (flush) begin
                pend_next[i] = '0;
            end else if (inc_vec[i] & ~dec_vec[i]) begin
                pend_next[i] = pend[i] + CNT_W'(1);
            end else if (dec_vec[i] & ~inc_vec[i]) begin
                if (pend[i] == '0) begin
                    underflow = 1'b1;
                end else begin
                    pend_next[i] = pend[i] - CNT_W'(1);
                end
            end
            mask_next[i] = (pend_next[i] != '0);
        end
    end

    // Counter, mask and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                pend[i] <= '0;
            end
            pending_mask <= '0;
            sb_err       <= 1'b0;
        end else begin
            pend         <= pend_next;
            pending_mask <= mask_next;
            if (underflow) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench for reg_scoreboard with reference model
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_advance, produces_dr, need_sr1, need_sr2, need_Hsr;
    logic [2:0] dec_dr, dec_sr1, dec_sr2;
    logic       wb_valid;
    logic [2:0] wb_dr;
    logic       flush;
    logic       stall, issue;
    logic [7:0] pending_mask;
    logic       sb_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       stall;
        logic       issue;
        logic [7:0] mask;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: number of in-flight writers per register, sticky error.
    int m_cnt [8];
    bit m_err;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_advance(dec_advance),
        .produces_dr(produces_dr), .need_sr1(need_sr1), .need_sr2(need_sr2),
        .need_Hsr(need_Hsr), .dec_dr(dec_dr), .dec_sr1(dec_sr1), .dec_sr2(dec_sr2),
        .wb_valid(wb_valid), .wb_dr(wb_dr), .flush(flush),
        .stall(stall), .issue(issue), .pending_mask(pending_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        for (int i = 0; i < 8; i++) m[i] = (m_cnt[i] > 0);
        return m;
    endfunction

    // One decode cycle: apply inputs, predict outputs, advance the model.
    task automatic cyc(input logic dv, adv, pd, s1, s2, hs,
                       input logic [2:0] dr, sr1, sr2,
                       input logic wb, input logic [2:0] wbd,
                       input logic fl, rst);
        bit   hz, iss;
        exp_t e;
        dec_valid = dv; dec_advance = adv; produces_dr = pd;
        need_sr1 = s1; need_sr2 = s2; need_Hsr = hs;
        dec_dr = dr; dec_sr1 = sr1; dec_sr2 = sr2;
        wb_valid = wb; wb_dr = wbd; flush = fl; reset = rst;
        hz = dv && ((s1 && m_cnt[sr1] > 0) || (s2 && m_cnt[sr2] > 0) ||
                    (hs && m_cnt[dr] > 0) || (pd && m_cnt[dr] == 3));
        iss = dv && adv && !hz && !fl;
        e.stall = hz; e.issue = iss; e.mask = model_mask(); e.err = m_err;
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 0;
        end else if (fl) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else begin
            if (iss && pd) m_cnt[dr]++;
            if (wb) begin
                if (m_cnt[wbd] == 0) m_err = 1;
                else m_cnt[wbd]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0,0,0,0,0,0, 3'd0,3'd0,3'd0, 0,3'd0, 0,0);
    endtask

    task automatic wr(input logic [2:0] r);
        cyc(1,1,1,0,0,0, r,3'd0,3'd0, 0,3'd0, 0,0);
    endtask

    task automatic ret(input logic [2:0] r);
        cyc(0,0,0,0,0,0, 3'd0,3'd0,3'd0, 1,r, 0,0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", {7'd0, stall}, {7'd0, e.stall});
                chk("issue", {7'd0, issue}, {7'd0, e.issue});
                chk("pending_mask", pending_mask, e.mask);
                chk("sb_err", {7'd0, sb_err}, {7'd0, e.err});
            end
        end
    end

    initial begin
        logic [2:0] r1, r2, r3, rw;
        reset = 1; dec_valid = 0; dec_advance = 0; produces_dr = 0;
        need_sr1 = 0; need_sr2 = 0; need_Hsr = 0; dec_dr = 0; dec_sr1 = 0; dec_sr2 = 0;
        wb_valid = 0; wb_dr = 0; flush = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        idle();
        // RAW on R3, retire while stalled, issue the cycle after
        wr(3'd3);
        cyc(1,1,1,1,0,0, 3'd4,3'd3,3'd2, 0,3'd0, 0,0);
        cyc(1,1,1,1,0,0, 3'd4,3'd3,3'd2, 1,3'd3, 0,0);
        cyc(1,1,1,1,0,0, 3'd4,3'd3,3'd2, 0,3'd0, 0,0);
        ret(3'd4);
        // store source hazard on R5
        wr(3'd5);
        cyc(1,1,0,0,0,1, 3'd5,3'd0,3'd0, 0,3'd0, 0,0);
        cyc(1,1,0,0,0,1, 3'd5,3'd0,3'd0, 1,3'd5, 0,0);
        cyc(1,1,0,0,0,1, 3'd5,3'd0,3'd0, 0,3'd0, 0,0);
        // saturation on R2
        wr(3'd2); wr(3'd2); wr(3'd2);
        wr(3'd2);
        cyc(1,1,1,0,0,0, 3'd2,3'd0,3'd0, 1,3'd2, 0,0);
        wr(3'd2);
        ret(3'd2); ret(3'd2); ret(3'd2);
        // simultaneous issue/retire on R6, then R1 issue with R6 retire
        wr(3'd6);
        cyc(1,1,1,0,0,0, 3'd6,3'd0,3'd0, 1,3'd6, 0,0);
        cyc(1,1,1,0,0,0, 3'd1,3'd0,3'd0, 1,3'd6, 0,0);
        idle();
        // branch with no flags never stalls
        cyc(1,1,0,0,0,0, 3'd1,3'd1,3'd1, 0,3'd0, 0,0);
        // flush with pend[1]=2, pend[7]=1 and a retire in the flush cycle
        wr(3'd1); wr(3'd7);
        cyc(0,0,0,0,0,0, 3'd0,3'd0,3'd0, 1,3'd1, 1,0);
        idle();
        ret(3'd1);
        idle(); idle();
        wr(3'd0);
        // reset mid-operation
        cyc(1,1,1,0,0,0, 3'd0,3'd0,3'd0, 1,3'd0, 0,1);
        idle();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            r1 = 3'($urandom_range(0,7)); r2 = 3'($urandom_range(0,7));
            r3 = 3'($urandom_range(0,7)); rw = 3'($urandom_range(0,7));
            cyc(1'($urandom_range(0,3) != 0), 1'($urandom_range(0,3) != 0),
                1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                1'($urandom_range(0,3) == 0),
                r1, r2, r3,
                1'($urandom_range(0,2) == 0), rw,
                1'($urandom_range(0,40) == 0), 1'($urandom_range(0,60) == 0));
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
